map_switch_ctrl: RTL and testbench
==================================

MAP_SWITCH_CTRL -- requirements
Module: map_switch_ctrl

Interface
REQ-001 Parameter: RST_CYCLES, default 8, number of cycles map_rst is held high (legal range 1..255).
REQ-002 Parameter: SETTLE_CYCLES, default 4, number of idle cycles after reset release before done (legal range 1..255).
REQ-003 Port: clk  in  1  system clock; all state changes on its rising edge.
REQ-004 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port: req_valid  in  1  mapper-switch request present.
REQ-006 Port: req_idx  in  8  requested mapper index.
REQ-007 Port: req_ready  out  1  request accepted this cycle when req_valid is also high.
REQ-008 Port: bus_idle  in  1  high when no CPU or PPU cart access is in progress.
REQ-009 Port: sel_idx  out  8  mapper index driven to the hub select.
REQ-010 Port: map_rst  out  1  synchronous reset to all mapper instances.
REQ-011 Port: busy  out  1  switch sequence in progress.
REQ-012 Port: done  out  1  one-cycle pulse at sequence completion.
REQ-013 Port: err  out  1  one-cycle pulse on a rejected request (only with MAP_SW_WHITELIST_EN).

Function
REQ-014 The FSM SHALL have the states IDLE, WAIT_IDLE, RESET and SETTLE.
REQ-015 req_ready SHALL be high only in IDLE; a request is accepted when req_valid and req_ready are both high.
REQ-016 Accept: latch req_idx into pend_idx; next state is WAIT_IDLE; busy rises in the next cycle.
REQ-017 WAIT_IDLE: on the first cycle with bus_idle high, load sel_idx from pend_idx, set map_rst to 1, load the counter with RST_CYCLES-1 and go to RESET.
REQ-018 RESET: map_rst stays at 1 while the counter decrements; at counter 0, clear map_rst, load the counter with SETTLE_CYCLES-1 and go to SETTLE.
REQ-019 SETTLE: decrement the counter; at 0, pulse done for one cycle, clear busy and return to IDLE in the same transition.
REQ-020 map_rst SHALL be high for exactly RST_CYCLES consecutive cycles per accepted request, and sel_idx SHALL change only on the cycle map_rst rises.
REQ-021 A request whose req_idx equals the current sel_idx SHALL still run the full sequence, which re-initialises the mapper.
REQ-022 Changes to req_valid or req_idx while busy SHALL be ignored; nothing is queued.
REQ-023 If bus_idle drops during RESET or SETTLE, the sequence SHALL continue unaffected.
REQ-024 done and err SHALL never be high in the same cycle.
REQ-025 The counter SHALL be 8 bits and SHALL never wrap (it is loaded on every state entry).

Reset
REQ-026 On rst_n low, asynchronously: state=IDLE, sel_idx=0 (nominal mapper), pend_idx=0, map_rst=1, busy=0, done=0, err=0, counter=0.
REQ-027 On the first clk edge after rst_n rises, map_rst SHALL go to 0.
REQ-028 Reset mid-sequence SHALL abort the sequence and discard pend_idx.

Configuration
REQ-029 Macro MAP_SW_WHITELIST_EN defined: only indices 0, 56, 103, 132, 134, 136, 172, 173, 186, 187, 221 and 254 are accepted.
REQ-030 Any other index SHALL still be handshaken, but SHALL pulse err for one cycle, stay in IDLE and leave sel_idx unchanged.
REQ-031 Macro undefined: every index is accepted, err SHALL be tied to 0, and there is no whitelist logic.

Verification
REQ-032 Reset release, then req_idx=56 with bus_idle=1: sel_idx=56 two cycles after accept, map_rst high 8 cycles, done 4 cycles after map_rst falls, busy low after done.
REQ-033 Request idx=103 with bus_idle=0 for 20 cycles: sel_idx and map_rst unchanged for those cycles; the sequence starts on the first cycle bus_idle=1.
REQ-034 Second request idx=134 issued while busy: req_ready=0, ignored; final sel_idx equals the first request's index.
REQ-035 rst_n pulsed low during RESET: sel_idx=0, busy=0, map_rst=1 immediately, map_rst=0 one edge after release, no done.
REQ-036 With MAP_SW_WHITELIST_EN, req_idx=57: err pulse, sel_idx unchanged, map_rst never asserted; without the macro: full sequence, sel_idx=57.
REQ-037 Request equal to current sel_idx (221 then 221): second request produces a full 8-cycle map_rst and a done pulse.

Source files
------------

// File: rtl/map_switch_ctrl.sv
// Mapper-switch sequencer: waits for an idle cart bus, re-selects the mapper under reset, then settles.
// Optional feature: define MAP_SW_WHITELIST_EN to reject requests for unsupported mapper indices.
module map_switch_ctrl #(
   parameter int unsigned RST_CYCLES    = 8,
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   input  logic [7:0] req_idx,
   output logic       req_ready,
   input  logic       bus_idle,
   output logic [7:0] sel_idx,
   output logic       map_rst,
   output logic       busy,
   output logic       done,
   output logic       err
);

   typedef enum logic [1:0] {IDLE, WAIT_IDLE, RESET, SETTLE} state_t;

   localparam logic [7:0] RST_LOAD    = 8'(RST_CYCLES - 1);
   localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

   state_t     state;
   logic [7:0] pend_idx;
   logic [7:0] cnt;
   logic       idx_ok;

   assign req_ready = (state == IDLE);

`ifdef MAP_SW_WHITELIST_EN
   function automatic logic idx_allowed(input logic [7:0] idx);
      case (idx)
         8'd0, 8'd56, 8'd103, 8'd132, 8'd134, 8'd136,
         8'd172, 8'd173, 8'd186, 8'd187, 8'd221, 8'd254: return 1'b1;
         default:                                       return 1'b0;
      endcase
   endfunction

   assign idx_ok = idx_allowed(req_idx);
`else
   assign idx_ok = 1'b1;
   assign err    = 1'b0;
`endif

   // NOTE: every state register uses <= so all updates in one edge see the pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         sel_idx  <= 8'd0;
         pend_idx <= 8'd0;
         map_rst  <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         cnt      <= 8'd0;
`ifdef MAP_SW_WHITELIST_EN
         err      <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
`ifdef MAP_SW_WHITELIST_EN
         err  <= 1'b0;
`endif
         case (state)
            IDLE: begin
               // Also ends the power-on mapper reset on the first edge after release.
               map_rst <= 1'b0;
               if (req_valid && idx_ok) begin
                  pend_idx <= req_idx;
                  busy     <= 1'b1;
                  state    <= WAIT_IDLE;
               end
`ifdef MAP_SW_WHITELIST_EN
               else if (req_valid) begin
                  err <= 1'b1;
               end
`endif
            end
            WAIT_IDLE: begin
               if (bus_idle) begin
                  sel_idx <= pend_idx;
                  map_rst <= 1'b1;
                  cnt     <= RST_LOAD;
                  state   <= RESET;
               end
            end
            RESET: begin
               if (cnt == 8'd0) begin
                  map_rst <= 1'b0;
                  cnt     <= SETTLE_LOAD;
                  state   <= SETTLE;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            SETTLE: begin
               if (cnt == 8'd0) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_map_switch_ctrl.sv
// Self-checking bench for map_switch_ctrl: directed scenarios plus random traffic against an event-timing model.
module tb_map_switch_ctrl;

   localparam int R = 8;
   localparam int S = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       req_valid = 1'b0;
   logic [7:0] req_idx = 8'd0;
   logic       bus_idle = 1'b0;
   logic       req_ready;
   logic [7:0] sel_idx;
   logic       map_rst;
   logic       busy;
   logic       done;
   logic       err;

   map_switch_ctrl #(.RST_CYCLES(R), .SETTLE_CYCLES(S)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_idx   (req_idx),
      .req_ready (req_ready),
      .bus_idle  (bus_idle),
      .sel_idx   (sel_idx),
      .map_rst   (map_rst),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   byte unsigned wl [12] = '{8'd0, 8'd56, 8'd103, 8'd132, 8'd134, 8'd136,
                             8'd172, 8'd173, 8'd186, 8'd187, 8'd221, 8'd254};

   // Reference model: a request is a timeline anchored on the edge the bus was first seen idle.
   bit         m_active, m_started, m_rst_pending;
   int         k, m_start, done_edge, err_edge;
   logic [7:0] m_idx, m_sel;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit allowed(input logic [7:0] idx);
`ifdef MAP_SW_WHITELIST_EN
      foreach (wl[i]) if (wl[i] == idx) return 1'b1;
      return 1'b0;
`else
      return (idx === idx);
`endif
   endfunction

   task automatic model_reset();
      m_active      = 1'b0;
      m_started     = 1'b0;
      m_rst_pending = 1'b1;
      m_sel         = 8'd0;
      m_idx         = 8'd0;
      done_edge     = -100;
      err_edge      = -100;
   endtask

   task automatic model_edge();
      k++;
      m_rst_pending = 1'b0;
      if (!m_active) begin
         if (req_valid) begin
            if (allowed(req_idx)) begin
               m_active  = 1'b1;
               m_started = 1'b0;
               m_idx     = req_idx;
            end else begin
               err_edge = k;
            end
         end
      end else if (!m_started) begin
         if (bus_idle) begin
            m_started = 1'b1;
            m_start   = k;
            m_sel     = m_idx;
         end
      end else if (k == m_start + R + S) begin
         m_active  = 1'b0;
         done_edge = k;
      end
   endtask

   task automatic check_outputs();
      bit exp_rst;
      exp_rst = m_rst_pending || (m_active && m_started && (k - m_start) < R);
      check("busy",      32'(busy),      32'(m_active));
      check("req_ready", 32'(req_ready), 32'(!m_active));
      check("sel_idx",   32'(sel_idx),   32'(m_sel));
      check("map_rst",   32'(map_rst),   32'(exp_rst));
      check("done",      32'(done),      32'(k == done_edge));
      check("err",       32'(err),       32'(k == err_edge));
      check("done_err_excl", 32'(done & err), 32'(0));
   endtask

   task automatic cyc(input logic v, input logic [7:0] idx, input logic idle);
      req_valid = v;
      req_idx   = idx;
      bus_idle  = idle;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      #1;
      check_outputs();
      @(posedge clk);
      @(negedge clk);
      check_outputs();
      rst_n = 1'b1;
   endtask

   task automatic idle_cycles(input int n, input logic idle);
      for (int i = 0; i < n; i++) cyc(1'b0, 8'd0, idle);
   endtask

   initial begin
      k = 0;
      m_start = 0;
      #1;
      do_reset();
      idle_cycles(2, 1'b1);

      // Basic switch to 56 with the bus already idle.
      cyc(1'b1, 8'd56, 1'b1);
      cyc(1'b0, 8'd0, 1'b1);
      check("sel_after_accept", 32'(sel_idx), 32'(56));
      idle_cycles(14, 1'b1);

      // Bus busy for 20 cycles delays the start.
      cyc(1'b1, 8'd103, 1'b0);
      idle_cycles(20, 1'b0);
      check("sel_held_while_bus_busy", 32'(sel_idx), 32'(56));
      idle_cycles(16, 1'b1);

      // Second request while busy is ignored.
      cyc(1'b1, 8'd187, 1'b1);
      for (int i = 0; i < 8; i++) cyc(1'b1, 8'd134, 1'b1);
      idle_cycles(10, 1'b1);
      check("first_request_wins", 32'(sel_idx), 32'(187));

      // Same index twice still runs the full sequence.
      cyc(1'b1, 8'd221, 1'b1);
      idle_cycles(15, 1'b1);
      cyc(1'b1, 8'd221, 1'b1);
      idle_cycles(15, 1'b1);

      // Index outside the whitelist.
      cyc(1'b1, 8'd57, 1'b1);
      idle_cycles(15, 1'b1);

      // Reset in the middle of the mapper reset phase.
      cyc(1'b1, 8'd172, 1'b1);
      idle_cycles(4, 1'b1);
      do_reset();
      idle_cycles(20, 1'b1);

      // Random traffic, including bus stalls and occasional resets.
      for (int n = 0; n < 2000; n++) begin
         logic       v;
         logic [7:0] idx;
         logic       idle;
         v    = ($urandom_range(0, 9) < 3);
         idx  = ($urandom_range(0, 1) == 0) ? 8'(wl[$urandom_range(0, 11)]) : 8'($urandom_range(0, 255));
         idle = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 199) == 0) do_reset();
         else cyc(v, idx, idle);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
